// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect/stall control from later stages, the
// instruction-memory read port and the registered IF/ID payload.
interface fetch_unit_if;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_done;
   logic [15:0] instruction;
   logic [15:0] pc_inc;
   logic        fetch_valid;
   logic        halted;

   // The fetch unit drives requests and the IF/ID payload.
   modport master (
      input  redirect, redirect_pc, stall, imem_data, imem_done,
      output imem_req, imem_addr, instruction, pc_inc, fetch_valid, halted
   );

   // Surrounding pipeline and memory model.
   modport slave (
      output redirect, redirect_pc, stall, imem_data, imem_done,
      input  imem_req, imem_addr, instruction, pc_inc, fetch_valid, halted
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory read at a time, a one-entry
// skid buffer for returns that arrive while decode is stalled, redirect
// handling (including a pending target for redirects during a read) and a
// HALT stop state that only a redirect can leave.
module fetch_unit (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   localparam logic [15:0] NOP_WORD = 16'h0800;

   typedef enum logic [1:0] {
      ST_ISSUE  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   // What the IF/ID output register does this cycle.
   typedef enum logic [1:0] {
      OUT_HOLD   = 2'd0,
      OUT_BUBBLE = 2'd1,
      OUT_MEM    = 2'd2,
      OUT_SKID   = 2'd3
   } out_sel_t;

   // Where the PC comes from next cycle.
   typedef enum logic [1:0] {
      PC_KEEP     = 2'd0,
      PC_REDIRECT = 2'd1,
      PC_PENDING  = 2'd2,
      PC_INC      = 2'd3
   } pc_sel_t;

   // A HALT is any word whose top five opcode bits are zero.
   function automatic logic is_halt(input logic [15:0] word);
      return (word[15:11] == 5'b00000);
   endfunction

   // Sequential fetch address; wraps silently at the top of memory.
   function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
      return pc + 16'd2;
   endfunction

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] pc_r;
   logic        pend_r;
   logic [15:0] pend_pc_r;
   logic [15:0] skid_instr_r;
   logic [15:0] skid_pc_inc_r;
   logic [15:0] instr_r;
   logic [15:0] pc_inc_r;
   logic        valid_r;
   logic        halted_r;

   out_sel_t    out_sel_s;
   pc_sel_t     pc_sel_s;
   logic        req_s;
   logic        pend_load_s;
   logic        pend_clr_s;
   logic        skid_load_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_ISSUE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; a redirect always returns the FSM to ISSUE except
   // while a read is still outstanding, where it is parked as pending.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_ISSUE: begin
            if (bus.redirect) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!bus.imem_done) begin
               state_next_s = ST_WAIT;
            end else if (bus.redirect || pend_r) begin
               state_next_s = ST_ISSUE;
            end else if (bus.stall) begin
               state_next_s = ST_HOLD;
            end else if (is_halt(bus.imem_data)) begin
               state_next_s = ST_HALTED;
            end else begin
               state_next_s = ST_ISSUE;
            end
         end
         ST_HOLD: begin
            if (bus.redirect) begin
               state_next_s = ST_ISSUE;
            end else if (bus.stall) begin
               state_next_s = ST_HOLD;
            end else if (is_halt(skid_instr_r)) begin
               state_next_s = ST_HALTED;
            end else begin
               state_next_s = ST_ISSUE;
            end
         end
         ST_HALTED: begin
            if (bus.redirect) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_HALTED;
            end
         end
         default: begin
            state_next_s = ST_ISSUE;
         end
      endcase
   end

   // Output and datapath-control decode. The baseline for the IF/ID register
   // is flush on redirect, hold on stall, otherwise bubble; states override
   // it only when an instruction is actually delivered.
   always_comb begin
      req_s       = 1'b0;
      pc_sel_s    = PC_KEEP;
      pend_load_s = 1'b0;
      pend_clr_s  = 1'b0;
      skid_load_s = 1'b0;
      if (bus.redirect) begin
         out_sel_s = OUT_BUBBLE;
      end else if (bus.stall) begin
         out_sel_s = OUT_HOLD;
      end else begin
         out_sel_s = OUT_BUBBLE;
      end
      case (state_r)
         ST_ISSUE: begin
            if (bus.redirect) begin
               pc_sel_s = PC_REDIRECT;
            end else if (rst) begin
               req_s = 1'b0;
            end else begin
               req_s = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus.imem_done) begin
               pend_clr_s = 1'b1;
               if (bus.redirect) begin
                  pc_sel_s = PC_REDIRECT;
               end else if (pend_r) begin
                  pc_sel_s = PC_PENDING;
               end else begin
                  pc_sel_s = PC_INC;
                  if (bus.stall) begin
                     skid_load_s = 1'b1;
                  end else begin
                     out_sel_s = OUT_MEM;
                  end
               end
            end else if (bus.redirect) begin
               pend_load_s = 1'b1;
            end else begin
               pend_load_s = 1'b0;
            end
         end
         ST_HOLD: begin
            if (bus.redirect) begin
               pc_sel_s = PC_REDIRECT;
            end else if (!bus.stall) begin
               out_sel_s = OUT_SKID;
            end else begin
               out_sel_s = OUT_HOLD;
            end
         end
         ST_HALTED: begin
            if (bus.redirect) begin
               pc_sel_s = PC_REDIRECT;
            end else begin
               pc_sel_s = PC_KEEP;
            end
         end
         default: begin
            pc_sel_s = PC_KEEP;
         end
      endcase
   end

   // Program counter; doubles as the memory request address.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= 16'h0000;
      end else begin
         case (pc_sel_s)
            PC_REDIRECT: pc_r <= bus.redirect_pc;
            PC_PENDING:  pc_r <= pend_pc_r;
            PC_INC:      pc_r <= pc_plus2(pc_r);
            default:     pc_r <= pc_r;
         endcase
      end
   end

   // Pending redirect target captured while a read is in flight; the newest
   // redirect wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r    <= 1'b0;
         pend_pc_r <= 16'h0000;
      end else if (pend_load_s) begin
         pend_r    <= 1'b1;
         pend_pc_r <= bus.redirect_pc;
      end else if (pend_clr_s) begin
         pend_r    <= 1'b0;
      end
   end

   // Skid buffer; its occupancy is implied by the HOLD state.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_instr_r  <= NOP_WORD;
         skid_pc_inc_r <= 16'h0000;
      end else if (skid_load_s) begin
         skid_instr_r  <= bus.imem_data;
         skid_pc_inc_r <= pc_plus2(pc_r);
      end
   end

   // IF/ID output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_r  <= NOP_WORD;
         pc_inc_r <= 16'h0000;
         valid_r  <= 1'b0;
      end else begin
         case (out_sel_s)
            OUT_MEM: begin
               instr_r  <= bus.imem_data;
               pc_inc_r <= pc_plus2(pc_r);
               valid_r  <= 1'b1;
            end
            OUT_SKID: begin
               instr_r  <= skid_instr_r;
               pc_inc_r <= skid_pc_inc_r;
               valid_r  <= 1'b1;
            end
            OUT_BUBBLE: begin
               instr_r  <= NOP_WORD;
               valid_r  <= 1'b0;
            end
            default: begin
               instr_r  <= instr_r;
            end
         endcase
      end
   end

   // Halted flag follows entry into and exit from the stop state.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_r <= 1'b0;
      end else begin
         halted_r <= (state_next_s == ST_HALTED);
      end
   end

   assign bus.imem_req    = req_s;
   assign bus.imem_addr   = pc_r;
   assign bus.instruction = instr_r;
   assign bus.pc_inc      = pc_inc_r;
   assign bus.fetch_valid = valid_r;
   assign bus.halted      = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// redirect/stall/memory-latency traffic, all checked against a transaction
// level reference model.
module tb_fetch_unit;
   localparam logic [15:0] NOP = 16'h0800;

   logic clk = 1'b0;
   logic rst;
   fetch_unit_if bus_if ();

   fetch_unit dut (.clk(clk), .rst(rst), .bus(bus_if));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: program counter, outstanding-read flag, pending target,
   // buffered words {word, address+2}, halt flag and the visible IF/ID payload.
   logic [15:0] m_pc;
   bit          m_wait;
   bit          m_pend;
   logic [15:0] m_pend_pc;
   logic [31:0] m_skid [$];
   bit          m_halted;
   logic [15:0] m_instr;
   logic [15:0] m_pcinc;
   bit          m_valid;

   // Memory responder state for the random phase.
   logic [15:0] mem [0:255];
   bit          mem_busy;
   int          mem_left;
   logic [15:0] mem_addr;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_req(input bit redir);
      return !m_wait && (m_skid.size() == 0) && !m_halted && !redir;
   endfunction

   task automatic deliver(input logic [31:0] e);
      m_instr = e[31:16];
      m_pcinc = e[15:0];
      m_valid = 1'b1;
      if (e[31:27] == 5'b00000) m_halted = 1'b1;
   endtask

   task automatic idle_out(input bit stl);
      if (!stl) begin
         m_instr = NOP;
         m_valid = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("instruction", bus_if.instruction, m_instr);
      chk("fetch_valid", {15'd0, bus_if.fetch_valid}, {15'd0, m_valid});
      chk("halted", {15'd0, bus_if.halted}, {15'd0, m_halted});
      if (m_valid) chk("pc_inc", bus_if.pc_inc, m_pcinc);
   endtask

   // One clock: drive inputs, check the request, advance model and DUT, check payload.
   task automatic cycle(input bit redir, input logic [15:0] rpc, input bit stl,
                        input bit dn, input logic [15:0] dat);
      bit          req_exp;
      logic [31:0] e;
      bus_if.redirect    = redir;
      bus_if.redirect_pc = rpc;
      bus_if.stall       = stl;
      bus_if.imem_done   = dn;
      bus_if.imem_data   = dat;
      #1;
      req_exp = model_req(redir);
      chk("imem_req", {15'd0, bus_if.imem_req}, {15'd0, req_exp});
      chk("imem_addr", bus_if.imem_addr, m_pc);
      if (redir) begin
         m_instr = NOP;
         m_valid = 1'b0;
         m_skid.delete();
         m_halted = 1'b0;
         if (m_wait && !dn) begin
            m_pend    = 1'b1;
            m_pend_pc = rpc;
         end else begin
            m_pc   = rpc;
            m_wait = 1'b0;
            m_pend = 1'b0;
         end
      end else if (m_wait && dn) begin
         m_wait = 1'b0;
         if (m_pend) begin
            m_pc   = m_pend_pc;
            m_pend = 1'b0;
            idle_out(stl);
         end else begin
            e    = {dat, m_pc + 16'd2};
            m_pc = m_pc + 16'd2;
            if (stl) m_skid.push_back(e);
            else deliver(e);
         end
      end else if ((m_skid.size() != 0) && !stl) begin
         deliver(m_skid.pop_front());
      end else begin
         if (req_exp) m_wait = 1'b1;
         idle_out(stl);
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // Drop all inputs so combinational request outputs can be inspected.
   task automatic quiet();
      bus_if.redirect  = 1'b0;
      bus_if.stall     = 1'b0;
      bus_if.imem_done = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_if.redirect    = 1'b0;
      bus_if.redirect_pc = 16'h0000;
      bus_if.stall       = 1'b0;
      bus_if.imem_done   = 1'b0;
      bus_if.imem_data   = 16'h0000;
      @(posedge clk);
      #1;
      chk("reset_req_low", {15'd0, bus_if.imem_req}, 16'd0);
      @(posedge clk);
      #1;
      m_pc = 16'h0000; m_wait = 1'b0; m_pend = 1'b0; m_pend_pc = 16'h0000;
      m_skid.delete(); m_halted = 1'b0;
      m_instr = NOP; m_pcinc = 16'h0000; m_valid = 1'b0;
      mem_busy = 1'b0;
      chk("reset_instruction", bus_if.instruction, NOP);
      chk("reset_pc_inc", bus_if.pc_inc, 16'h0000);
      chk("reset_valid", {15'd0, bus_if.fetch_valid}, 16'd0);
      chk("reset_halted", {15'd0, bus_if.halted}, 16'd0);
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] w;
      bit          r, s, d, req_now;
      logic [15:0] rp, dt, a_now;

      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom());
         if (w[15:11] == 5'b00000) w[11] = 1'b1;
         if ($urandom_range(0, 39) == 0) w[15:11] = 5'b00000;
         mem[i] = w;
      end

      // Reset, then abandon a read with a second reset; a stale done in the
      // first ISSUE cycle must be ignored and the first request goes to 0.
      do_reset();
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      do_reset();
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777);
      chk("r027_stale_done_ignored", {15'd0, bus_if.fetch_valid}, 16'd0);

      // Basic one-cycle-latency fetch.
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
      chk("r029_instr", bus_if.instruction, 16'h1234);
      chk("r029_pc_inc", bus_if.pc_inc, 16'h0002);
      chk("r029_valid", {15'd0, bus_if.fetch_valid}, 16'd1);
      quiet();
      chk("r029_next_addr", bus_if.imem_addr, 16'h0002);

      // Stall at the return of 0xABCD for three cycles.
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'hABCD);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      chk("r030_held", bus_if.instruction, 16'h1234);
      quiet();
      chk("r030_no_req_in_hold", {15'd0, bus_if.imem_req}, 16'd0);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      chk("r030_instr", bus_if.instruction, 16'hABCD);
      chk("r030_valid", {15'd0, bus_if.fetch_valid}, 16'd1);
      quiet();
      chk("r030_next_addr", bus_if.imem_addr, 16'h0004);

      // Redirect during a read; the late return is discarded.
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cycle(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h3333);
      chk("r031_discard_valid", {15'd0, bus_if.fetch_valid}, 16'd0);
      quiet();
      chk("r031_next_addr", bus_if.imem_addr, 16'h0100);

      // PC wrap at the top of memory.
      cycle(1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5555);
      chk("r032_pc_inc_wrap", bus_if.pc_inc, 16'h0000);
      quiet();
      chk("r032_next_addr", bus_if.imem_addr, 16'h0000);

      // HALT delivery, stop, then redirect out of the halted state.
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000);
      chk("r033_halt_valid", {15'd0, bus_if.fetch_valid}, 16'd1);
      chk("r033_halted", {15'd0, bus_if.halted}, 16'd1);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      quiet();
      chk("r033_no_req", {15'd0, bus_if.imem_req}, 16'd0);
      cycle(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000);
      chk("r033_unhalted", {15'd0, bus_if.halted}, 16'd0);
      quiet();
      chk("r033_req", {15'd0, bus_if.imem_req}, 16'd1);
      chk("r033_addr", bus_if.imem_addr, 16'h0040);

      // Redirect beats stall while the skid buffer is full.
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222);
      cycle(1'b1, 16'h0300, 1'b1, 1'b0, 16'h0000);
      chk("r034_flush_instr", bus_if.instruction, NOP);
      chk("r034_flush_valid", {15'd0, bus_if.fetch_valid}, 16'd0);
      quiet();
      chk("r034_req", {15'd0, bus_if.imem_req}, 16'd1);
      chk("r034_addr", bus_if.imem_addr, 16'h0300);

      // Random traffic with variable memory latency.
      mem_busy = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 9) == 0);
         rp = 16'($urandom()) & 16'hFFFE;
         if ($urandom_range(0, 3) == 0) rp = 16'hFFF8 | (rp & 16'h0006);
         s  = ($urandom_range(0, 2) == 0);
         d  = mem_busy && (mem_left == 1);
         dt = d ? mem[mem_addr[8:1]] : 16'($urandom());
         req_now = model_req(r);
         a_now   = m_pc;
         cycle(r, rp, s, d, dt);
         if (d) mem_busy = 1'b0;
         else if (mem_busy) mem_left--;
         if (req_now) begin
            mem_busy = 1'b1;
            mem_left = $urandom_range(1, 4);
            mem_addr = a_now;
         end
         if ($urandom_range(0, 399) == 0) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL use one clock and synchronous, active-high reset: clk input 1 (all state updates on rising edge); rst input 1 (synchronous, active-high).
REQ-002 Redirect input 1: execute stage resolved a taken branch or jump this cycle.
REQ-003 Redirect_PC input 16: target address from execute (PC_Next), valid when Redirect=1.
REQ-004 Stall input 1: decode cannot accept a new instruction this cycle.
REQ-005 IMem_Req output 1: one-cycle instruction-memory read request.
REQ-006 IMem_Addr output 16: request address, equal to the PC register.
REQ-007 IMem_Data input 16 and IMem_Done input 1: read data, valid when IMem_Done=1.
REQ-008 Instruction output 16 and PC_Inc output 16: registered IF/ID payload (instruction word, its address+2).
REQ-009 Fetch_Valid output 1: Instruction/PC_Inc hold a real instruction (0 = bubble).
REQ-010 Halted output 1: fetch stopped on a delivered HALT.

Function
REQ-011 PC SHALL be a 16-bit register; increment is +2 modulo 2^16 (0xFFFE -> 0x0000, no flag).
REQ-012 FSM states SHALL be ISSUE, WAIT, HOLD, HALTED.
REQ-013 ISSUE: IMem_Req=1, IMem_Addr=PC; next WAIT; if Redirect=1, no request counts, PC<=Redirect_PC, stay ISSUE.
REQ-014 WAIT: IMem_Req=0, IMem_Addr held; IMem_Done is only sampled in WAIT (earliest one cycle after request, unbounded latency).
REQ-015 WAIT with Redirect=1 and IMem_Done=0: store target in a pending register, set pending flag; a later Redirect overwrites the stored target.
REQ-016 WAIT with IMem_Done=1 and (pending flag or Redirect): discard data, PC<=newest target (current Redirect_PC over pending), clear pending, go ISSUE.
REQ-017 WAIT with IMem_Done=1, no redirect, Stall=0: Instruction<=IMem_Data, PC_Inc<=PC+2, Fetch_Valid<=1, PC<=PC+2, go ISSUE (HALTED if IMem_Data[15:11]=5'b00000).
REQ-018 WAIT with IMem_Done=1, no redirect, Stall=1: capture data and PC+2 in a one-entry skid buffer, PC<=PC+2, go HOLD.
REQ-019 HOLD: IMem_Req=0; when Stall=0 and no Redirect, move buffer to outputs with Fetch_Valid<=1, go ISSUE (HALTED if buffered opcode is HALT).
REQ-020 Redirect SHALL take priority over Stall in every state: output register flushed to Instruction=16'h0800 (NOP), Fetch_Valid=0, skid buffer discarded.
REQ-021 Redirect in HOLD or HALTED: PC<=Redirect_PC, Halted<=0, go ISSUE (wrong-path HALT cancelled).
REQ-022 Stall=1 without Redirect: output register holds its value unchanged.
REQ-023 Stall=0 and no instruction delivered this cycle: output becomes bubble (NOP, Fetch_Valid=0).
REQ-024 HALTED: IMem_Req=0, Halted=1, PC frozen, output becomes bubble after the HALT is accepted by decode (Stall=0).
REQ-025 Minimum latency: request in cycle N, Done in N+1, Fetch_Valid=1 in N+2; peak throughput one instruction per two cycles.

Reset
REQ-026 rst=1 SHALL set PC=0x0000, state=ISSUE, pending flag=0, skid buffer empty, Instruction=16'h0800, PC_Inc=0x0000, Fetch_Valid=0, Halted=0; IMem_Req=0 during reset.
REQ-027 Reset mid-transaction SHALL abandon the outstanding request; an IMem_Done arriving in the first ISSUE cycle after reset is ignored.
REQ-028 First request (IMem_Addr=0x0000) SHALL be issued in the first cycle after rst deasserts.

Verification
REQ-029 Reset release, memory returns 0x1234 at 0x0000 with 1-cycle latency, Stall=0 -> IMem_Req pulses at 0x0000, then Instruction=0x1234, PC_Inc=0x0002, Fetch_Valid=1; next request at 0x0002.
REQ-030 Stall=1 at Done of 0xABCD, held 3 cycles -> previous output held, state HOLD, no request; Stall drop -> Instruction=0xABCD, Fetch_Valid=1, next request at old PC+2.
REQ-031 Redirect to 0x0100 while WAIT, Done 3 cycles later -> returned data discarded, Fetch_Valid=0, next IMem_Addr=0x0100.
REQ-032 PC=0xFFFE, no redirect -> PC_Inc=0x0000, next request at 0x0000.
REQ-033 Returned 16'h0000 (HALT) -> delivered with Fetch_Valid=1, Halted=1, no further IMem_Req; subsequent Redirect to 0x0040 -> Halted=0, request at 0x0040.
REQ-034 Redirect and Stall both 1 in HOLD -> buffer dropped, Instruction=0x0800, Fetch_Valid=0, request at Redirect_PC next cycle.
